tdm_i2s_tx: RTL and testbench
=============================

Name: tdm_i2s_tx

Overview:
- Parametrised I2S/TDM serial transmitter, the successor to the fixed 2-channel transmitter.
- Generates its own word-select/frame-sync (WS) from the bclk_falling tick of the clock generator.
- Serialises CHANNELS samples per frame, with configurable slot width, data width and data delay.
- Accepts whole frames through a valid/ready handshake into a one-deep holding buffer, with underrun detection.
- Sits between the audio pipeline and the DAC/codec pins.

Parameters:
- DATA_BITS, 24: sample width per channel.
- SLOT_BITS, 32: BCLKs per channel slot; must be >= DATA_BITS + DELAY.
- CHANNELS, 2: slots per frame, 2..8.
- DELAY, 1: data delay in BCLKs after slot start. 1 = I2S, 0 = left-justified/DSP.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- bclk_falling, in, 1: single-cycle tick; all serial state advances only on this tick.
- enable, in, 1: run control.
- s_data, in, CHANNELS*DATA_BITS: frame; channel 0 in the LSBs.
- s_valid, in, 1: frame valid.
- s_ready, out, 1: holding buffer empty.
- ws, out, 1: word select / frame sync.
- sdata, out, 1: serial data.
- frame_start, out, 1: one-clk pulse when a frame begins.
- underrun, out, 1: one-clk pulse when a frame begins with no data.

Behaviour:
- Reset values: ws=0, sdata=0, frame_start=0, underrun=0, s_ready=1. Counters and buffers clear to 0.
- Position state: bit_cnt 0..SLOT_BITS-1 and slot_cnt 0..CHANNELS-1.
- Each bclk_falling tick while running: bit_cnt increments. At SLOT_BITS-1 it wraps to 0 and slot_cnt increments; slot_cnt wraps CHANNELS-1 -> 0.
- ws, sdata: registered, updated only on bclk_falling ticks, both reflecting the new position.
- ws when CHANNELS==2: 0 during slot 0 (left), 1 during slot 1 (right), 50% duty.
- ws when CHANNELS>2: 1 only at slot 0, bit 0 (one-BCLK pulse), else 0.
- sdata at slot s, bit b:
  - If DELAY <= b < DELAY+DATA_BITS: bit (DATA_BITS-1-(b-DELAY)) of channel s, MSB first.
  - Otherwise 0 (delay and padding positions).
- States:
  - IDLE: outputs 0, counters held at 0.
  - RUN: entered on the first bclk_falling with enable=1. That tick drives slot 0, bit 0 and is a frame start.
  - RUN -> IDLE: when enable=0 is sampled at the next frame boundary, i.e. the tick that would otherwise start a new frame. The current frame always completes.
- Frame start tick:
  - Holding buffer full: holding transfers into the frame register in the same cycle and the buffer empties (s_ready rises next clk).
  - Holding buffer empty: frame register cleared to 0 (silence) and underrun pulses.
  - frame_start pulses in both cases.
  - The DELAY=0 first bit must come from the incoming data (bypass mux).
- Handshake:
  - Accept when s_valid & s_ready; holding fills and s_ready=0 from the next clk.
  - Accept coinciding with a frame start: the holding-to-frame transfer happens first, then the new frame is accepted into the emptied holding register. No frame is dropped or duplicated.
  - s_ready does not depend on s_valid combinationally.
- Holding buffer is not flushed by enable=0; it is cleared only by reset.
- Reset mid-frame: immediate return to IDLE with all outputs 0.
- Ticks arriving while enable=0 in IDLE have no effect.

Decomposition:
- Shared package tdm_i2s_pkg:
  - Constants DELAY_I2S=1, DELAY_LJ=0.
  - Constants for the counter widths, $clog2(SLOT_BITS) and $clog2(CHANNELS).
- One natural sub-module, tdm_slot_counter: bit_cnt/slot_cnt with wrap, frame_boundary and ws generation. The top level holds the buffers, handshake and serialiser.

Test Plan:
- I2S stereo (defaults):
  - Stimulus: frame L=24'hA5A5A5, R=24'h0F0F0F, enable=1.
  - Response: ws 0 for 32 ticks, then 1 for 32. sdata on ticks 1..24 = A5A5A5 MSB first; tick 0 and ticks 25..31 = 0. R follows the same pattern in slot 1.
- Left-justified (DELAY=0, DATA_BITS=16, SLOT_BITS=16):
  - Stimulus: L=16'h8001.
  - Response: sdata=1 on the first tick of the slot (same tick ws falls), 1 on tick 15, else 0.
- TDM (CHANNELS=4, SLOT_BITS=32):
  - Stimulus: channels 0x111111, 0x222222, 0x333333, 0x444444.
  - Response: ws high only 1 tick per 128. Each slot carries its channel at bits 1..24.
- Underrun:
  - Stimulus: enable=1 with no s_valid for 2 frames.
  - Response: sdata=0 throughout; underrun and frame_start pulse once per frame (2 each).
- Back-pressure:
  - Stimulus: s_valid held high with an incrementing frame counter.
  - Response: s_ready=0 until each frame start. Transmitted frames are 1,2,3... with no skips or repeats, including accepts on the frame-start cycle.
- Enable/reset:
  - Stimulus: enable=0 mid-frame.
  - Response: the frame completes, then ws=sdata=0.
  - Stimulus: rst_n=0 mid-slot.
  - Response: all outputs 0 immediately, s_ready=1.

Source files
------------

// File: rtl/tdm_i2s_pkg.sv
// Shared types, constants and helpers for the TDM/I2S transmitter.
package tdm_i2s_pkg;

  // Data delay presets: I2S puts the MSB one BCLK after the slot start.
  // Left-justified and DSP formats put it on the slot start.
  localparam int DELAY_I2S = 1;
  localparam int DELAY_LJ  = 0;

  // Transmitter run state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for a modulo-n counter. Returns at least 1 so that
  // n == 1 still gives a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_i2s_if.sv
// Frame stream interface: one whole frame per valid/ready transfer.
interface tdm_i2s_if #(
  parameter int CHANNELS  = 2,
  parameter int DATA_BITS = 24
) ();

  logic [CHANNELS*DATA_BITS-1:0] s_data;   // channel 0 in the LSBs
  logic                          s_valid;
  logic                          s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/tdm_slot_counter.sv
// Bit/slot position counter with frame boundary detection and WS generation.
// The counter exposes the position the next tick will move to, so the
// serialiser can look up the data bit for that position in the same cycle.
module tdm_slot_counter
  import tdm_i2s_pkg::*;
#(
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,      // bclk_falling
  input  logic                          run,       // currently running
  input  logic                          go,        // running after this tick
  output logic                          frame_boundary,
  output logic [cnt_w(SLOT_BITS)-1:0]   bit_next,
  output logic [cnt_w(CHANNELS)-1:0]    slot_next,
  output logic                          ws
);

  localparam int BIT_W  = cnt_w(SLOT_BITS);
  localparam int SLOT_W = cnt_w(CHANNELS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);

  logic [BIT_W-1:0]  bit_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic              bit_last;
  logic              slot_last;
  logic              ws_next;

  assign bit_last       = (bit_reg == BIT_LAST);
  assign slot_last      = (slot_reg == SLOT_LAST);
  assign frame_boundary = run && bit_last && slot_last;

  // Next position: advance while running, otherwise sit at slot 0 bit 0
  // (which is also where a fresh start from idle lands).
  always_comb begin
    bit_next  = '0;
    slot_next = '0;
    if (go && run) begin
      if (bit_last) begin
        bit_next  = '0;
        slot_next = slot_last ? '0 : slot_reg + SLOT_W'(1);
      end else begin
        bit_next  = bit_reg + BIT_W'(1);
        slot_next = slot_reg;
      end
    end
  end

  // Stereo uses a 50% duty left/right select; TDM uses a one-BCLK frame sync.
  generate
    if (CHANNELS == 2) begin : g_ws_stereo
      assign ws_next = go && (slot_next == SLOT_W'(1));
    end else begin : g_ws_tdm
      assign ws_next = go && (slot_next == '0) && (bit_next == '0);
    end
  endgenerate

  // Position and WS only move on BCLK falling ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_reg  <= '0;
      slot_reg <= '0;
      ws       <= 1'b0;
    end else if (tick) begin
      bit_reg  <= bit_next;
      slot_reg <= slot_next;
      ws       <= ws_next;
    end
  end

endmodule

// File: rtl/tdm_i2s_tx.sv
// Parametrised I2S/TDM serial transmitter with a one-deep frame holding
// buffer, frame register and MSB-first serialiser.
module tdm_i2s_tx
  import tdm_i2s_pkg::*;
#(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int DELAY     = DELAY_I2S
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     bclk_falling,
  input  logic     enable,
  tdm_i2s_if.slave s_if,
  output logic     ws,
  output logic     sdata,
  output logic     frame_start,
  output logic     underrun
);

  localparam int FRAME_BITS = CHANNELS * DATA_BITS;
  localparam int BIT_W      = cnt_w(SLOT_BITS);
  localparam int SLOT_W     = cnt_w(CHANNELS);
  localparam int DATA_W     = cnt_w(DATA_BITS);

  state_t                  state_reg, state_next;
  logic                    frame_start_c;
  logic                    go;
  logic                    frame_boundary;
  logic [BIT_W-1:0]        bit_next;
  logic [SLOT_W-1:0]       slot_next;
  logic [FRAME_BITS-1:0]   hold_reg;
  logic                    hold_full_reg;
  logic [FRAME_BITS-1:0]   frame_reg;
  logic [FRAME_BITS-1:0]   frame_src;
  logic                    accept;
  logic                    sdata_next;
  logic [DATA_BITS-1:0]    chan [CHANNELS];
  int                      b_idx;
  logic [DATA_W-1:0]       msb_idx;

  // Run state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Start on the first enabled tick; stop only at a frame boundary so the
  // current frame always finishes.
  always_comb begin
    state_next    = state_reg;
    frame_start_c = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bclk_falling && enable) begin
          state_next    = RUN;
          frame_start_c = 1'b1;
        end
      end
      RUN: begin
        if (bclk_falling && frame_boundary) begin
          if (enable) frame_start_c = 1'b1;
          else        state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign go = (state_next == RUN);

  tdm_slot_counter #(
    .SLOT_BITS (SLOT_BITS),
    .CHANNELS  (CHANNELS)
  ) u_slot_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (bclk_falling),
    .run            (state_reg == RUN),
    .go             (go),
    .frame_boundary (frame_boundary),
    .bit_next       (bit_next),
    .slot_next      (slot_next),
    .ws             (ws)
  );

  // s_ready is purely the buffer state, never a function of s_valid.
  assign s_if.s_ready = !hold_full_reg;
  assign accept       = s_if.s_valid && !hold_full_reg;

  // Holding buffer and frame register. A frame start drains the holding
  // buffer (or loads silence); an accept can only land in an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      frame_reg     <= '0;
    end else begin
      if (frame_start_c) frame_reg <= hold_full_reg ? hold_reg : '0;
      if (accept) begin
        hold_reg      <= s_if.s_data;
        hold_full_reg <= 1'b1;
      end else if (frame_start_c) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  // On a frame start the frame register is still stale, so serialise
  // straight from the data being loaded (needed when DELAY is 0).
  assign frame_src = frame_start_c ? (hold_full_reg ? hold_reg : '0) : frame_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = frame_src[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // Pick the data bit for the next position; delay and padding bits are 0.
  always_comb begin
    sdata_next = 1'b0;
    msb_idx    = '0;
    b_idx      = int'(bit_next) - DELAY;
    if (go && (b_idx >= 0) && (b_idx < DATA_BITS)) begin
      msb_idx    = DATA_W'(DATA_BITS - 1 - b_idx);
      sdata_next = chan[slot_next][msb_idx];
    end
  end

  // Registered serial data and per-frame status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_start_c;
      underrun    <= frame_start_c && !hold_full_reg;
      if (bclk_falling) sdata <= sdata_next;
    end
  end

endmodule

// File: tb/tb_tdm_i2s_tx.sv
// Directed bench for tdm_i2s_tx: I2S stereo, left-justified, TDM-4,
// underrun, back-pressure, enable drop and reset.
module tb_tdm_i2s_tx;
  import tdm_i2s_pkg::*;

  logic clk;
  logic rst_n;
  logic bclk_falling;
  logic en_i2s, en_lj, en_tdm;
  logic ws_i2s, sd_i2s, fs_i2s, ur_i2s;
  logic ws_lj,  sd_lj,  fs_lj,  ur_lj;
  logic ws_tdm, sd_tdm, fs_tdm, ur_tdm;
  logic fs_i2s_p, ur_i2s_p, fs_lj_p, fs_tdm_p;

  int checks;
  int errors;
  logic bp_on;
  int   bp_val;

  tdm_i2s_if #(.CHANNELS(2), .DATA_BITS(24)) if_i2s ();
  tdm_i2s_if #(.CHANNELS(2), .DATA_BITS(16)) if_lj ();
  tdm_i2s_if #(.CHANNELS(4), .DATA_BITS(24)) if_tdm ();

  tdm_i2s_tx #(.DATA_BITS(24), .SLOT_BITS(32), .CHANNELS(2), .DELAY(DELAY_I2S)) u_i2s (
    .clk(clk), .rst_n(rst_n), .bclk_falling(bclk_falling), .enable(en_i2s),
    .s_if(if_i2s.slave), .ws(ws_i2s), .sdata(sd_i2s), .frame_start(fs_i2s), .underrun(ur_i2s)
  );

  tdm_i2s_tx #(.DATA_BITS(16), .SLOT_BITS(16), .CHANNELS(2), .DELAY(DELAY_LJ)) u_lj (
    .clk(clk), .rst_n(rst_n), .bclk_falling(bclk_falling), .enable(en_lj),
    .s_if(if_lj.slave), .ws(ws_lj), .sdata(sd_lj), .frame_start(fs_lj), .underrun(ur_lj)
  );

  tdm_i2s_tx #(.DATA_BITS(24), .SLOT_BITS(32), .CHANNELS(4), .DELAY(DELAY_I2S)) u_tdm (
    .clk(clk), .rst_n(rst_n), .bclk_falling(bclk_falling), .enable(en_tdm),
    .s_if(if_tdm.slave), .ws(ws_tdm), .sdata(sd_tdm), .frame_start(fs_tdm), .underrun(ur_tdm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] mk_frame(input int n);
    return {24'hC00000 | 24'(n), 24'(n)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; in back-pressure mode a handshake seen at this edge
  // advances the source to the next frame number.
  task automatic clk_step();
    logic acc;
    acc = bp_on && if_i2s.s_valid && if_i2s.s_ready;
    @(negedge clk);
    if (acc) begin
      bp_val++;
      if_i2s.s_data = mk_frame(bp_val);
    end
  endtask

  // One BCLK falling tick followed by one quiet clock.
  task automatic tick();
    bclk_falling = 1'b1;
    clk_step();
    fs_i2s_p = fs_i2s;
    ur_i2s_p = ur_i2s;
    fs_lj_p  = fs_lj;
    fs_tdm_p = fs_tdm;
    bclk_falling = 1'b0;
    clk_step();
  endtask

  // 64 ticks of the stereo I2S instance; enable drops before tick drop_at.
  task automatic i2s_frame(input int drop_at, output logic [31:0] l, output logic [31:0] r,
                           output logic [63:0] w, output int fs, output int ur);
    l = '0; r = '0; w = '0; fs = 0; ur = 0;
    for (int t = 0; t < 64; t++) begin
      if (t == drop_at) en_i2s = 1'b0;
      tick();
      w = {w[62:0], ws_i2s};
      if (t < 32) l = {l[30:0], sd_i2s};
      else        r = {r[30:0], sd_i2s};
      fs += int'(fs_i2s_p);
      ur += int'(ur_i2s_p);
    end
  endtask

  initial begin
    logic [31:0] l, r;
    logic [63:0] w, sd64, ws64;
    logic [31:0] sw [4];
    int fs, ur, fs_tot, ur_tot, ws_cnt;
    logic sd_or, ws_first, sd_first;

    checks = 0; errors = 0; bp_on = 1'b0; bp_val = 0;
    bclk_falling = 1'b0; en_i2s = 1'b0; en_lj = 1'b0; en_tdm = 1'b0;
    if_i2s.s_data = '0; if_i2s.s_valid = 1'b0;
    if_lj.s_data  = '0; if_lj.s_valid  = 1'b0;
    if_tdm.s_data = '0; if_tdm.s_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ws",    64'(ws_i2s), 64'(1'b0));
    check("rst_sdata", 64'(sd_i2s), 64'(1'b0));
    check("rst_fs",    64'(fs_i2s), 64'(1'b0));
    check("rst_ur",    64'(ur_i2s), 64'(1'b0));
    check("rst_ready", 64'(if_i2s.s_ready), 64'(1'b1));
    check("rst_tdm_ws", 64'(ws_tdm), 64'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // Ticks while disabled do nothing
    fs_tot = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      fs_tot += int'(fs_i2s_p);
    end
    check("idle_fs", 64'(fs_tot), 64'(0));
    check("idle_ws", 64'(ws_i2s), 64'(1'b0));

    // I2S stereo frame
    if_i2s.s_data = {24'h0F0F0F, 24'hA5A5A5};
    if_i2s.s_valid = 1'b1;
    clk_step();
    if_i2s.s_valid = 1'b0;
    check("i2s_ready_full", 64'(if_i2s.s_ready), 64'(1'b0));
    en_i2s = 1'b1;
    i2s_frame(-1, l, r, w, fs, ur);
    check("i2s_left",  64'(l), 64'({1'b0, 24'hA5A5A5, 7'b0}));
    check("i2s_right", 64'(r), 64'({1'b0, 24'h0F0F0F, 7'b0}));
    check("i2s_ws",    w, 64'h00000000_FFFFFFFF);
    check("i2s_fs",    64'(fs), 64'(1));
    check("i2s_ur",    64'(ur), 64'(0));
    check("i2s_ready_empty", 64'(if_i2s.s_ready), 64'(1'b1));

    // Underrun: two frames with no data
    fs_tot = 0; ur_tot = 0; sd_or = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i2s_frame(-1, l, r, w, fs, ur);
      fs_tot += fs; ur_tot += ur;
      sd_or = sd_or | (|l) | (|r);
    end
    check("ur_fs",    64'(fs_tot), 64'(2));
    check("ur_count", 64'(ur_tot), 64'(2));
    check("ur_sdata", 64'(sd_or), 64'(1'b0));

    // Back-pressure: first accept lands on a frame-start tick with an empty
    // buffer, so that frame is silent and frames 1,2,3 follow in order.
    bp_on = 1'b1; bp_val = 1;
    if_i2s.s_data = mk_frame(1);
    if_i2s.s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i2s_frame(-1, l, r, w, fs, ur);
      check($sformatf("bp_left_%0d", k),  64'(l), 64'({1'b0, 24'(k), 7'b0}));
      check($sformatf("bp_right_%0d", k), 64'(r),
            64'({1'b0, (k == 0) ? 24'h0 : (24'hC00000 | 24'(k)), 7'b0}));
      check($sformatf("bp_ur_%0d", k),    64'(ur), 64'((k == 0) ? 1 : 0));
      check($sformatf("bp_ready_%0d", k), 64'(if_i2s.s_ready), 64'(1'b0));
    end
    bp_on = 1'b0;
    if_i2s.s_valid = 1'b0;

    // Enable drop mid-frame: frame 4 completes, then silence
    i2s_frame(10, l, r, w, fs, ur);
    check("en_left",  64'(l), 64'({1'b0, 24'h000004, 7'b0}));
    check("en_right", 64'(r), 64'({1'b0, 24'hC00004, 7'b0}));
    check("en_ws",    w, 64'h00000000_FFFFFFFF);
    check("en_fs",    64'(fs), 64'(1));
    tick();
    check("en_stop_ws",    64'(ws_i2s), 64'(1'b0));
    check("en_stop_sdata", 64'(sd_i2s), 64'(1'b0));
    check("en_stop_fs",    64'(fs_i2s_p), 64'(1'b0));
    check("en_stop_ready", 64'(if_i2s.s_ready), 64'(1'b1));

    // Holding buffer survives idle ticks, then feeds the next run
    if_i2s.s_data = mk_frame(9);
    if_i2s.s_valid = 1'b1;
    clk_step();
    if_i2s.s_valid = 1'b0;
    tick(); tick();
    check("idle_hold_ready", 64'(if_i2s.s_ready), 64'(1'b0));
    en_i2s = 1'b1;
    l = '0;
    for (int t = 0; t < 41; t++) begin
      tick();
      if (t < 32) l = {l[30:0], sd_i2s};
    end
    check("hold_left", 64'(l), 64'({1'b0, 24'h000009, 7'b0}));
    check("pre_rst_ws", 64'(ws_i2s), 64'(1'b1));
    if_i2s.s_data = mk_frame(10);
    if_i2s.s_valid = 1'b1;
    clk_step();
    if_i2s.s_valid = 1'b0;
    check("pre_rst_ready", 64'(if_i2s.s_ready), 64'(1'b0));

    // Reset mid-slot
    rst_n = 1'b0;
    #1;
    check("mid_rst_ws",    64'(ws_i2s), 64'(1'b0));
    check("mid_rst_sdata", 64'(sd_i2s), 64'(1'b0));
    check("mid_rst_fs",    64'(fs_i2s), 64'(1'b0));
    check("mid_rst_ur",    64'(ur_i2s), 64'(1'b0));
    check("mid_rst_ready", 64'(if_i2s.s_ready), 64'(1'b1));
    en_i2s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Left-justified 16/16: two frames of L=8001, R=0
    if_lj.s_data = {16'h0000, 16'h8001};
    if_lj.s_valid = 1'b1;
    clk_step();
    if_lj.s_valid = 1'b0;
    en_lj = 1'b1;
    sd64 = '0; ws64 = '0; fs = 0; sd_first = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (t == 40) en_lj = 1'b0;
      tick();
      if (t == 0) sd_first = sd_lj;
      sd64 = {sd64[62:0], sd_lj};
      ws64 = {ws64[62:0], ws_lj};
      fs += int'(fs_lj_p);
      if (t == 0) begin
        if_lj.s_data = {16'h0000, 16'h8001};
        if_lj.s_valid = 1'b1;
        clk_step();
        if_lj.s_valid = 1'b0;
      end
    end
    check("lj_first_bit", 64'(sd_first), 64'(1'b1));
    check("lj_sdata", sd64, {16'h8001, 16'h0000, 16'h8001, 16'h0000});
    check("lj_ws",    ws64, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF});
    check("lj_fs",    64'(fs), 64'(2));
    tick();
    check("lj_stop_ws", 64'(ws_lj), 64'(1'b0));

    // TDM-4
    if_tdm.s_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    if_tdm.s_valid = 1'b1;
    clk_step();
    if_tdm.s_valid = 1'b0;
    en_tdm = 1'b1;
    for (int s = 0; s < 4; s++) sw[s] = '0;
    ws_cnt = 0; fs = 0; ws_first = 1'b0;
    for (int t = 0; t < 128; t++) begin
      if (t == 64) en_tdm = 1'b0;
      tick();
      if (t == 0) ws_first = ws_tdm;
      sw[t/32] = {sw[t/32][30:0], sd_tdm};
      ws_cnt += int'(ws_tdm);
      fs += int'(fs_tdm_p);
    end
    check("tdm_slot0", 64'(sw[0]), 64'({1'b0, 24'h111111, 7'b0}));
    check("tdm_slot1", 64'(sw[1]), 64'({1'b0, 24'h222222, 7'b0}));
    check("tdm_slot2", 64'(sw[2]), 64'({1'b0, 24'h333333, 7'b0}));
    check("tdm_slot3", 64'(sw[3]), 64'({1'b0, 24'h444444, 7'b0}));
    check("tdm_ws_first", 64'(ws_first), 64'(1'b1));
    check("tdm_ws_count", 64'(ws_cnt), 64'(1));
    check("tdm_fs", 64'(fs), 64'(1));
    tick();
    check("tdm_stop_ws", 64'(ws_tdm), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
